// File: rtl/fifo_rd_scheduler_pkg.sv
// fifo_rd_scheduler_pkg: shared state encoding and counter sizing for the read scheduler
package fifo_rd_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, ARB, BURST, DRAIN, RELEASE} state_t;
  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction
endpackage

// File: rtl/fifo_rd_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot pick of the first set request at or after the pointer, wrapping
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);
  logic hit;
  int   j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!hit && req_i[j]) begin
        hit      = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/fifo_rd_scheduler.sv
// fifo_rd_scheduler: round-robin burst sharing of an async FIFO read port with a 2-entry output buffer
module fifo_rd_scheduler
  import fifo_rd_scheduler_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [WIDTH-1:0]   fifo_rd_data,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);
  localparam int CW = cnt_w(BURST_LEN);
  localparam int PW = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, owner_q, owner_d, arb_idx;
  logic [NUM_REQ-1:0] grant_q, grant_d, arb_gnt;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               abort_q, abort_d, inflight_q, infl_last_q, head_q, tail_q;
  logic               push, pop, owner_req, abort_now;
  logic [1:0]         occ_q, pend, last_q;
  logic [WIDTH-1:0]   mem_q [2];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );

  assign owner_req = req[owner_q];
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;
  assign pend      = occ_q + 2'(inflight_q) - 2'(pop);
  assign abort_now = state_q == BURST && cnt_q != '0 && !owner_req;
  // A same-cycle pop frees a slot, which lets a streaming burst sustain one word per cycle
  assign fifo_rd_en = state_q == BURST && !fifo_empty && cnt_q != '0 && owner_req && pend < 2'd2;
  assign out_valid  = occ_q != 2'd0;
  assign out_data   = mem_q[head_q];
  // After an abort the final word is the one standing alone with nothing still in flight
  assign out_last   = out_valid && (last_q[head_q] || ((abort_q || abort_now) && occ_q == 2'd1 && !inflight_q));
  assign grant      = grant_q;
  assign busy       = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    owner_d = owner_q;
    abort_d = abort_q;
    cnt_d   = fifo_rd_en ? cnt_q - 1'b1 : cnt_q;
    case (state_q)
      IDLE:    state_d = |req ? ARB : IDLE;
      ARB: begin
        state_d = |req ? BURST : IDLE;
        if (|req) begin
          grant_d = arb_gnt;
          owner_d = arb_idx;
          cnt_d   = CW'(BURST_LEN);
        end
      end
      BURST: begin
        if (cnt_q == '0 || !owner_req) begin
          state_d = DRAIN;
          abort_d = abort_now;
        end
      end
      DRAIN:   state_d = (occ_q == 2'd0 && !inflight_q) ? RELEASE : DRAIN;
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
        abort_d = 1'b0;
        ptr_d   = owner_q == PW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      occ_q       <= 2'd0;
      last_q      <= 2'b00;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      inflight_q  <= fifo_rd_en;
      infl_last_q <= cnt_q == CW'(1);
      if (push) begin
        mem_q[tail_q]  <= fifo_rd_data;
        last_q[tail_q] <= infl_last_q;
        tail_q         <= ~tail_q;
      end
      if (pop) head_q <= ~head_q;
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// tb_fifo_rd_scheduler: directed scenarios checked against a FIFO/scoreboard model of the scheduler
module tb_fifo_rd_scheduler;
  localparam int BL = 8;

  typedef struct packed {logic [3:0] g; logic [7:0] d;} srv_t;
  typedef struct {logic [7:0] d; logic l; logic [3:0] g; int c;} pop_t;

  logic       clk = 1'b0, rst = 1'b1, fifo_empty, fifo_rd_en, out_valid, out_ready = 1'b1, out_last, busy;
  logic       force_empty = 1'b0;
  logic [3:0] req = '0, grant, prev_g = '0;
  logic [7:0] fifo_rd_data = '0, out_data, nextval = '0;
  logic [7:0] src_mem [1024];
  logic [3:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         wr_ix = 0, rd_ix = 0, sq_ix = 0, srv_total = 0, cyc = 0, falls = 0;
  int         burst_pops = 0, last_cnt = 0, tests = 0, fails = 0;
  srv_t       served_q[$];
  pop_t       plog[$];
  logic [3:0] gseq[$];

  fifo_rd_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  assign fifo_empty = force_empty || (wr_ix == rd_ix);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Source FIFO: a read pops one word, visible on fifo_rd_data the next cycle
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en && wr_ix != rd_ix) begin
      fifo_rd_data <= src_mem[rd_ix];
      if (!rst) begin
        served_q.push_back('{g: grant, d: src_mem[rd_ix]});
        srv_total++;
      end
      rd_ix++;
    end
    if (rst) served_q.delete();
  end

  // Every served word must come out once, in order, to its owner; one last per burst
  always @(negedge clk) begin
    if (rst) begin
      sq_ix = 0; burst_pops = 0; last_cnt = 0; prev_g = '0;
    end else begin
      chk("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 0);
      chk("grant_onehot0", 32'($onehot0(grant)), 1);
      chk("outstanding_le2", 32'(served_q.size() - sq_ix <= 2), 1);
      if (prev_g == '0 && grant != '0) begin
        gseq.push_back(grant); burst_pops = 0; last_cnt = 0;
      end
      if (out_valid && out_ready) begin
        chk("word_pending", 32'(served_q.size() > sq_ix), 1);
        if (served_q.size() > sq_ix) begin
          chk("word_data", out_data, served_q[sq_ix].d);
          chk("word_grant", grant, served_q[sq_ix].g);
          sq_ix++;
          chk("last_only_when_drained", 32'(out_last && served_q.size() > sq_ix), 0);
        end
        burst_pops++;
        last_cnt += int'(out_last);
        if (burst_pops == BL) chk("last_at_burst_len", out_last, 1);
        plog.push_back('{d: out_data, l: out_last, g: grant, c: cyc});
      end
      if (prev_g != '0 && grant == '0) begin
        falls++;
        chk("burst_fully_delivered", served_q.size() - sq_ix, 0);
        chk("one_last_per_burst", last_cnt, 32'(burst_pops != 0));
      end
      prev_g = grant;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      src_mem[wr_ix] = nextval; nextval++; wr_ix++;
    end
  endtask

  task automatic wait_srv(input int n, input int budget);
    for (int k = 0; k < budget && srv_total < n; k++) tick;
    chk("wait_served", 32'(srv_total >= n), 1);
  endtask

  task automatic wait_fall(input int n, input int budget);
    for (int k = 0; k < budget && falls < n; k++) tick;
    chk("wait_release", 32'(falls >= n), 1);
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int k = 0; k < budget && plog.size() < n; k++) tick;
    chk("wait_pops", 32'(plog.size() >= n), 1);
  endtask

  task automatic wait_grant(input int budget);
    for (int k = 0; k < budget && grant == '0; k++) tick;
    chk("wait_grant", 32'(grant != '0), 1);
  endtask

  task automatic check_log(input int s, input int n, input logic [7:0] v, input logic [3:0] g);
    chk("log_len", 32'(plog.size() >= s + n), 1);
    for (int i = 0; i < n; i++)
      if (s + i < plog.size()) begin
        chk("log_data", plog[s+i].d, 8'(v + i));
        chk("log_last", plog[s+i].l, 32'(i == n - 1));
        chk("log_grant", plog[s+i].g, g);
      end
  endtask

  initial begin
    int s0, f0, p0;
    logic [7:0] v0;
    tick; tick;
    chk("rst_grant", grant, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    tick;
    // round robin over all four requesters
    nextval = 8'h20; load(40);
    s0 = srv_total; f0 = falls; p0 = plog.size(); gseq.delete();
    req = 4'hF;
    wait_srv(s0 + 40, 600);
    req = '0;
    wait_fall(f0 + 5, 100);
    chk("rr_grants", gseq.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < gseq.size()) chk("rr_order", gseq[k], exp_rr[k]);
      check_log(p0 + 8 * k, 8, 8'(8'h20 + 8 * k), exp_rr[k]);
    end
    // single requester streaming
    nextval = 8'h10; load(8);
    s0 = srv_total; f0 = falls; p0 = plog.size();
    req = 4'b0001;
    wait_grant(10);
    chk("single_grant", grant, 4'b0001);
    wait_srv(s0 + 8, 100);
    req = '0;
    wait_fall(f0 + 1, 100);
    check_log(p0, 8, 8'h10, 4'b0001);
    if (plog.size() >= p0 + 8) chk("single_back_to_back", plog[p0+7].c - plog[p0].c, 7);
    chk("single_idle_grant", grant, 0);
    // empty stall toggling every 3 cycles
    nextval = 8'h30; load(8);
    s0 = srv_total; f0 = falls; p0 = plog.size();
    req = 4'b0001;
    for (int k = 0; k < 300 && srv_total < s0 + 8; k++) begin
      force_empty = ((k / 3) % 2) == 0;
      tick;
    end
    force_empty = 1'b0;
    chk("stall_served", srv_total - s0, 8);
    req = '0;
    wait_fall(f0 + 1, 100);
    check_log(p0, 8, 8'h30, 4'b0001);
    // backpressure mid-burst
    nextval = 8'h40; load(8);
    s0 = srv_total; f0 = falls; p0 = plog.size();
    req = 4'b0001;
    wait_pops(p0 + 2, 50);
    out_ready = 1'b0;
    repeat (10) tick;
    chk("bp_outstanding", served_q.size() - sq_ix, 2);
    chk("bp_no_rd_en", fifo_rd_en, 0);
    chk("bp_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_srv(s0 + 8, 100);
    req = '0;
    wait_fall(f0 + 1, 100);
    check_log(p0, 8, 8'h40, 4'b0001);
    chk("bp_no_dup", plog.size() - p0, 8);
    // reset mid-burst, pointer must restart at requester 0
    nextval = 8'h50; load(8);
    s0 = srv_total;
    req = 4'b0100;
    wait_srv(s0 + 4, 50);
    chk("rst_mid_owner", grant, 4'b0100);
    rst = 1'b1;
    tick;
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rd_en", fifo_rd_en, 0);
    rst = 1'b0; req = '0;
    tick;
    f0 = falls;
    req = 4'hF;
    wait_grant(10);
    chk("rst_ptr_restart", grant, 4'b0001);
    req = '0;
    wait_fall(f0 + 1, 50);
    // abort after three words, next grant goes to requester 3
    v0 = src_mem[rd_ix];
    load(8);
    s0 = srv_total; f0 = falls; p0 = plog.size();
    req = 4'b0100;
    wait_srv(s0 + 3, 50);
    req = '0;
    wait_fall(f0 + 1, 100);
    chk("abort_count", plog.size() - p0, 3);
    check_log(p0, 3, v0, 4'b0100);
    load(3);
    req = 4'b1100;
    wait_grant(10);
    chk("abort_next_owner", grant, 4'b1000);
    req = 4'b1000;
    s0 = srv_total;
    wait_srv(s0 + 8, 100);
    req = '0;
    wait_fall(f0 + 2, 100);
    check_log(p0 + 3, 8, 8'(v0 + 3), 4'b1000);
    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end
endmodule
